// File: rtl/seq_mul_add.sv
// Iterative shift-add multiply-accumulate: p = q*d + r.
// One multiplier bit per clock, fixed DW-cycle latency.
module seq_mul_add #(
  parameter int QW = 8,
  parameter int DW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [QW-1:0]    q,
  input  logic [DW-1:0]    d,
  input  logic [DW-1:0]    r,
  output logic [QW+DW-1:0] p,
  output logic             busy,
  output logic             done,
  output logic             r_err
);

  localparam int PW = QW + DW;
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [DW-1:0]   mplier_q, mplier_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   acc_sum;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   p_q, p_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            rerr_q, rerr_d;

  // Next-state, datapath step and result capture.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rerr_d   = rerr_q;
    acc_sum  = mplier_q[0] ? acc_q + mcand_q : acc_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d  = {{DW{1'b0}}, q};
          mplier_d = d;
          acc_d    = {{QW{1'b0}}, r};
          err_d    = (r >= d);
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          p_d     = acc_sum;
          rerr_d  = err_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any op in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      p_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rerr_q   <= rerr_d;
    end
  end

  assign p     = p_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign r_err = rerr_q;

endmodule

// File: tb/tb_seq_mul_add.sv
// Directed and random checks for seq_mul_add.
// Inputs change and outputs are sampled on the falling edge.
module tb_seq_mul_add;

  localparam int QW = 8;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [QW-1:0] q;
  logic [DW-1:0] d;
  logic [DW-1:0] r;
  logic [QW+DW-1:0] p;
  logic          busy;
  logic          done;
  logic          r_err;

  int errors = 0;
  int checks = 0;

  seq_mul_add #(.QW(QW), .DW(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .q     (q),
    .d     (d),
    .r     (r),
    .p     (p),
    .busy  (busy),
    .done  (done),
    .r_err (r_err)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; q = '0; d = '0; r = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({p, busy, done, r_err} !== 15'd0) begin
      errors++;
      $display("FAIL reset: p=%0d busy=%b done=%b r_err=%b want all 0",
               p, busy, done, r_err);
    end
  endtask

  // Exact-latency op: busy for DW cycles, done one cycle, p held after.
  task automatic run_op(input string nm, input logic [QW-1:0] qi,
                        input logic [DW-1:0] di, input logic [DW-1:0] ri,
                        input logic [QW+DW-1:0] ep, input logic ee);
    q = qi; d = di; r = ri; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < DW; i++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s busy[%0d]: busy=%b done=%b want 1 0",
                 nm, i, busy, done);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || p !== ep || r_err !== ee) begin
      errors++;
      $display("FAIL %s result: done=%b busy=%b p=%0d r_err=%b want 1 0 %0d %b",
               nm, done, busy, p, r_err, ep, ee);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || p !== ep || r_err !== ee) begin
      errors++;
      $display("FAIL %s hold: done=%b p=%0d r_err=%b want 0 %0d %b",
               nm, done, p, r_err, ep, ee);
    end
  endtask

  task automatic test_basic();
    run_op("t1", 8'd37, 4'd5, 4'd3, 12'd188, 1'b0);
  endtask

  task automatic test_extremes();
    run_op("max", 8'd255, 4'd15, 4'd14, 12'd3839, 1'b0);
    run_op("zero", 8'd0, 4'd0, 4'd0, 12'd0, 1'b1);
    run_op("d0", 8'd200, 4'd0, 4'd9, 12'd9, 1'b1);
  endtask

  task automatic test_rerr();
    run_op("rerr", 8'd9, 4'd2, 4'd7, 12'd25, 1'b1);
  endtask

  // start held high; operands scrambled while busy must not matter.
  task automatic test_back_to_back();
    logic [QW-1:0] vq [4] = '{8'd3, 8'd100, 8'd250, 8'd17};
    logic [DW-1:0] vd [4] = '{4'd7, 4'd9, 4'd15, 4'd1};
    logic [DW-1:0] vr [4] = '{4'd2, 4'd12, 4'd0, 4'd0};
    logic [QW+DW-1:0] vp [4] = '{12'd23, 12'd912, 12'd3750, 12'd17};
    logic ve [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int k = 0;
    int cyc = 0;
    q = vq[0]; d = vd[0]; r = vr[0]; start = 1'b1;
    while (k < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        checks++;
        if (p !== vp[k] || r_err !== ve[k]) begin
          errors++;
          $display("FAIL b2b[%0d]: p=%0d r_err=%b want %0d %b",
                   k, p, r_err, vp[k], ve[k]);
        end
        k++;
        if (k < 4) begin
          q = vq[k]; d = vd[k]; r = vr[k];
        end else begin
          start = 1'b0;
        end
      end else if (busy) begin
        q = 8'($urandom); d = 4'($urandom); r = 4'($urandom);
      end
    end
    start = 1'b0;
    checks++;
    if (k !== 4) begin
      errors++;
      $display("FAIL b2b count: got %0d results want 4", k);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    q = 8'd200; d = 4'd11; r = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (p !== 12'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: p=%0d busy=%b done=%b want 0 0 0",
               p, busy, done);
    end
    run_op("post_rst", 8'd12, 4'd3, 4'd1, 12'd37, 1'b0);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int n = 0; n < 1000; n++) begin
      logic [QW-1:0] rq;
      logic [DW-1:0] rd, rr;
      logic [QW+DW-1:0] ep;
      int w;
      int nd;
      rq = 8'($urandom); rd = 4'($urandom); rr = 4'($urandom);
      ep = 12'(int'(rq) * int'(rd) + int'(rr));
      q = rq; d = rd; r = rr; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      w = 0; nd = 0;
      while (!done && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (done) nd++;
      checks++;
      if (done !== 1'b1 || p !== ep || r_err !== (rr >= rd)) begin
        errors++;
        if (bad < 10)
          $display("FAIL rand[%0d] q=%0d d=%0d r=%0d: p=%0d e=%b want %0d %b",
                   n, rq, rd, rr, p, r_err, ep, rr >= rd);
        bad++;
      end
      @(negedge clk);
      if (done) nd++;
      checks++;
      if (nd !== 1) begin
        errors++;
        if (bad < 10)
          $display("FAIL rand_done[%0d]: pulses=%0d want 1", n, nd);
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_rerr();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
